ins_loader: RTL

INS_LOADER -- requirements
Module: ins_loader

---
 rtl/ins_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ins_loader.sv
// ins_loader - streams a program image into a CPU instruction memory.
//
// Byte stream: a CNT_W/8-byte word count N (MSB first), then N 32-bit
// instruction words (MSB first). The CPU is held in reset while loading.
// Optional macro INS_LOADER_CHECKSUM_EN adds one trailer byte. The trailer
// is compared against the XOR of all header and payload bytes, and ERR
// reports the result.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   START         load request (honoured in IDLE/DONE only)
//   IN_DATA/IN_VALID/IN_READY  byte stream handshake
//   W_Ins, WE     instruction word and one-cycle write strobe
//   CPU_RST       CPU reset hold, released in DONE
//   BUSY, DONE    status
//   WORD_CNT      words written since the last START
//   ERR           checksum mismatch (tied 0 without the macro)
//
// state | meaning
// IDLE  | waiting for START after reset
// HDR   | collecting the word-count header
// LOAD  | collecting the 4 bytes of one instruction word
// WR    | single-cycle write strobe of the assembled word
// CHK   | collecting the checksum trailer (macro builds only)
// DONE  | image loaded, CPU released, waiting for a new START
module ins_loader #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [7:0]       IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [31:0]      W_Ins,
    output logic             WE,
    output logic             CPU_RST,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic             ERR
);

    localparam int HDR_BYTES = CNT_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_WR,
`ifdef INS_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    // State entered once the last word has been written.
`ifdef INS_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_cnt_inc;
    logic [CNT_W-1:0] n_shift;
    logic [7:0]       hdr_idx;
    logic [1:0]       byte_idx;
    logic [31:0]      shreg;
    logic [31:0]      shift_word;
    logic [31:0]      w_ins;
    logic             hdr_last;
    logic             accept;
    logic             start_ok;

    assign accept       = IN_READY && IN_VALID;
    assign start_ok     = START && (state == S_IDLE || state == S_DONE);
    assign n_shift      = (n_reg << 8) | CNT_W'(IN_DATA);
    assign shift_word   = {shreg[23:0], IN_DATA};
    assign hdr_last     = (hdr_idx == 8'(HDR_BYTES - 1));
    assign word_cnt_inc = word_cnt + 1'b1;
    assign W_Ins        = w_ins;
    assign WORD_CNT     = word_cnt;

    always_comb begin
        state_nx = state;
        IN_READY = 1'b0;
        WE       = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        CPU_RST  = 1'b1;
        case (state)
            S_IDLE: begin
                if (START) state_nx = S_HDR;
            end
            S_HDR: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (IN_VALID && hdr_last)
                    state_nx = (n_shift == '0) ? S_FIN : S_LOAD;
            end
            S_LOAD: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (IN_VALID && byte_idx == 2'd3) state_nx = S_WR;
            end
            S_WR: begin
                WE = 1'b1;
                // Compare the post-increment count so N = 2^CNT_W-1 still ends.
                state_nx = (word_cnt_inc == n_reg) ? S_FIN : S_LOAD;
            end
`ifdef INS_LOADER_CHECKSUM_EN
            S_CHK: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (IN_VALID) state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                CPU_RST = 1'b0;
                DONE    = 1'b1;
                if (START) state_nx = S_HDR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef INS_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            n_reg    <= '0;
            word_cnt <= '0;
            hdr_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            w_ins    <= '0;
`ifdef INS_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (start_ok) begin
                n_reg    <= '0;
                word_cnt <= '0;
                hdr_idx  <= '0;
                byte_idx <= '0;
`ifdef INS_LOADER_CHECKSUM_EN
                csum     <= '0;
                err_q    <= 1'b0;
`endif
            end
            if (accept) begin
                case (state)
                    S_HDR: begin
                        n_reg   <= n_shift;
                        hdr_idx <= hdr_idx + 1'b1;
`ifdef INS_LOADER_CHECKSUM_EN
                        csum    <= csum ^ IN_DATA;
`endif
                    end
                    S_LOAD: begin
                        shreg    <= shift_word;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) w_ins <= shift_word;
`ifdef INS_LOADER_CHECKSUM_EN
                        csum     <= csum ^ IN_DATA;
`endif
                    end
`ifdef INS_LOADER_CHECKSUM_EN
                    S_CHK: err_q <= (IN_DATA != csum);
`endif
                    default: ;
                endcase
            end
            if (state == S_WR) word_cnt <= word_cnt_inc;
        end
    end

endmodule
